// File: rtl/ce_gen_pkg.sv
// ce_gen_pkg: shared definitions for the multi-channel clock-enable generator.
//   ch_idx_w()   width of a channel index (never less than 1 bit)
//   ch_state_e   per-channel run state
//   CNT_W_DEF    default divisor/counter width
package ce_gen_pkg;

   localparam int CNT_W_DEF = 16;

   typedef enum logic [0:0] {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } ch_state_e;

   function automatic int ch_idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ce_gen_channel.sv
// ce_gen_channel: one clock-enable channel (counter, active/shadow divisor,
// pending flag, STOP/RUN state). Optional square-wave output is built only
// when CE_GEN_SQ_OUT_EN is defined; otherwise sq is tied low.
//
// Ports:
//   clk_from_FPGA  board clock
//   rst_from_FPGA  asynchronous active-low reset
//   run            level enable for this channel
//   wr_en          divisor write for this channel (already qualified by ready)
//   wr_data        new divisor
//   ce             registered one-cycle enable pulse
//   sq             registered square wave, toggles on every ce pulse
//   pending        shadow divisor waiting for the next terminal count
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_STOP | idle: counter 0, outputs low, writes go straight to active_div
// ST_RUN  | counting: writes land in shadow, applied at terminal count
import ce_gen_pkg::*;

module ce_gen_channel #(
   parameter int CNT_W       = CNT_W_DEF,
   parameter int DEFAULT_DIV = 101
) (
   input  logic             clk_from_FPGA,
   input  logic             rst_from_FPGA,
   input  logic             run,
   input  logic             wr_en,
   input  logic [CNT_W-1:0] wr_data,
   output logic             ce,
   output logic             sq,
   output logic             pending
);

   ch_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] act_q, act_d;
   logic [CNT_W-1:0] shd_q, shd_d;
   logic             pend_q, pend_d;
   logic             ce_q, ce_d;
   logic [CNT_W-1:0] term;
   logic             at_term;

   // Divisor 0 behaves as 1, so the terminal value is 0 in both cases.
   always_comb begin
      term    = (act_q == '0) ? '0 : act_q - CNT_W'(1);
      at_term = (cnt_q == term);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      act_d   = act_q;
      shd_d   = shd_q;
      pend_d  = pend_q;
      ce_d    = 1'b0;
      // The edge that first samples run high already counts, so the
      // first pulse lands exactly eff_div edges after run is seen.
      if (run) begin
         state_d = ST_RUN;
         if (at_term) begin
            cnt_d = '0;
            ce_d  = 1'b1;
            if (pend_q) begin
               act_d  = shd_q;
               pend_d = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         state_d = ST_STOP;
         cnt_d   = '0;
         if (pend_q) begin
            act_d  = shd_q;
            pend_d = 1'b0;
         end
      end
      // Placed after the terminal-count update so a write on the terminal
      // edge becomes pending instead of being consumed by that boundary.
      if (wr_en) begin
         if (state_q == ST_STOP) begin
            act_d = wr_data;
         end else begin
            shd_d  = wr_data;
            pend_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_from_FPGA or negedge rst_from_FPGA) begin
      if (!rst_from_FPGA) begin
         state_q <= ST_STOP;
         cnt_q   <= '0;
         act_q   <= CNT_W'(DEFAULT_DIV);
         shd_q   <= CNT_W'(DEFAULT_DIV);
         pend_q  <= 1'b0;
         ce_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         act_q   <= act_d;
         shd_q   <= shd_d;
         pend_q  <= pend_d;
         ce_q    <= ce_d;
      end
   end

`ifdef CE_GEN_SQ_OUT_EN
   logic sq_q, sq_d;

   always_comb begin
      sq_d = run ? (sq_q ^ at_term) : 1'b0;
   end

   always_ff @(posedge clk_from_FPGA or negedge rst_from_FPGA) begin
      if (!rst_from_FPGA) begin
         sq_q <= 1'b0;
      end else begin
         sq_q <= sq_d;
      end
   end

   assign sq = sq_q;
`else
   assign sq = 1'b0;
`endif

   assign ce      = ce_q;
   assign pending = pend_q;

endmodule

// File: rtl/ce_gen_multi.sv
// ce_gen_multi: NUM_CH independent clock-enable generators in the board
// clock domain, with runtime divisor writes that take effect only on period
// boundaries. Square-wave outputs exist only when CE_GEN_SQ_OUT_EN is defined.
//
// Ports:
//   clk_from_FPGA  board clock
//   rst_from_FPGA  asynchronous active-low reset
//   run            per-channel level enable
//   div_wr_en      divisor write request
//   div_wr_ch      target channel (out-of-range writes are dropped)
//   div_wr_data    new divisor
//   div_wr_ready   write accepted on an edge with div_wr_en && div_wr_ready
//   ce_out         per-channel one-cycle enable pulse
//   sq_out         per-channel 50 % square wave
import ce_gen_pkg::*;

module ce_gen_multi #(
   parameter int  NUM_CH      = 2,
   parameter int  CNT_W       = CNT_W_DEF,
   parameter int  DEFAULT_DIV = 101,
   localparam int CH_W        = ch_idx_w(NUM_CH)
) (
   input  logic              clk_from_FPGA,
   input  logic              rst_from_FPGA,
   input  logic [NUM_CH-1:0] run,
   input  logic              div_wr_en,
   input  logic [CH_W-1:0]   div_wr_ch,
   input  logic [CNT_W-1:0]  div_wr_data,
   output logic              div_wr_ready,
   output logic [NUM_CH-1:0] ce_out,
   output logic [NUM_CH-1:0] sq_out
);

   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] wr_sel;
   logic              rdy;

   // A channel holding a pending divisor refuses further writes until the
   // boundary applies it; unmatched channel indices stay ready and drop.
   always_comb begin
      rdy    = 1'b1;
      wr_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (div_wr_ch == CH_W'(i)) begin
            rdy       = !pending[i];
            wr_sel[i] = div_wr_en && !pending[i];
         end
      end
   end

   assign div_wr_ready = rdy;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      ce_gen_channel #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_from_FPGA (clk_from_FPGA),
         .rst_from_FPGA (rst_from_FPGA),
         .run           (run[g]),
         .wr_en         (wr_sel[g]),
         .wr_data       (div_wr_data),
         .ce            (ce_out[g]),
         .sq            (sq_out[g]),
         .pending       (pending[g])
      );
   end

endmodule

// File: tb/tb_ce_gen_multi.sv
// Testbench for ce_gen_multi: directed stimulus pushes expected pulse times
// into per-channel queues; a negedge monitor pops and compares on every pulse.
module tb_ce_gen_multi;

   localparam int NUM_CH = 2;
   localparam int CNT_W  = 16;
   localparam int CH_W   = 1;
`ifdef CE_GEN_SQ_OUT_EN
   localparam bit SQ_EN = 1'b1;
`else
   localparam bit SQ_EN = 1'b0;
`endif

   logic              clk_from_FPGA = 1'b0;
   logic              rst_from_FPGA;
   logic [NUM_CH-1:0] run;
   logic              div_wr_en;
   logic [CH_W-1:0]   div_wr_ch;
   logic [CNT_W-1:0]  div_wr_data;
   logic              div_wr_ready;
   logic [NUM_CH-1:0] ce_out;
   logic [NUM_CH-1:0] sq_out;

   typedef struct {
      int cyc;
      bit sq;
   } exp_t;

   exp_t exp_q [NUM_CH][$];
   bit   sq_m  [NUM_CH];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   ce_gen_multi #(
      .NUM_CH      (NUM_CH),
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (101)
   ) dut (
      .clk_from_FPGA (clk_from_FPGA),
      .rst_from_FPGA (rst_from_FPGA),
      .run           (run),
      .div_wr_en     (div_wr_en),
      .div_wr_ch     (div_wr_ch),
      .div_wr_data   (div_wr_data),
      .div_wr_ready  (div_wr_ready),
      .ce_out        (ce_out),
      .sq_out        (sq_out)
   );

   always #5 clk_from_FPGA = ~clk_from_FPGA;

   always @(posedge clk_from_FPGA) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Queue n pulses for a channel starting at edge 'first', spaced 'period'.
   task automatic push_pulses(input int ch, input int first, input int period, input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         sq_m[ch] = ~sq_m[ch];
         e.cyc = first + k * period;
         e.sq  = sq_m[ch];
         exp_q[ch].push_back(e);
      end
   endtask

   // Returns 2 time units after the negedge following edge t.
   task automatic go_until(input int t);
      while (cyc < t) begin
         @(negedge clk_from_FPGA);
         #2;
      end
   endtask

   task automatic do_write(input int ch, input int d, input bit exp_rdy);
      div_wr_ch   = ch[CH_W-1:0];
      div_wr_data = d[CNT_W-1:0];
      div_wr_en   = 1'b1;
      #1;
      chk("wr_ready_before_write", {31'd0, div_wr_ready}, {31'd0, exp_rdy});
      go_until(cyc + 1);
      div_wr_en = 1'b0;
   endtask

   always @(negedge clk_from_FPGA) begin
      exp_t e;
      if (rst_from_FPGA === 1'b1) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ce_out[i] === 1'b1) begin
               checks++;
               if (exp_q[i].size() == 0) begin
                  failures++;
                  $display("FAIL ce_unexpected ch%0d: pulse at cycle %0d, none expected", i, cyc);
               end else begin
                  e = exp_q[i].pop_front();
                  if (e.cyc != cyc || sq_out[i] !== (SQ_EN & e.sq)) begin
                     failures++;
                     $display("FAIL ce_pulse ch%0d: got cycle %0d sq %b expected cycle %0d sq %b",
                              i, cyc, sq_out[i], e.cyc, SQ_EN & e.sq);
                  end
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int s;
      rst_from_FPGA = 1'b0;
      run           = '0;
      div_wr_en     = 1'b0;
      div_wr_ch     = '0;
      div_wr_data   = '0;
      for (int i = 0; i < NUM_CH; i++) sq_m[i] = 1'b0;

      // Reset state
      go_until(3);
      chk("rst_ce_out", {30'd0, ce_out}, 32'd0);
      chk("rst_sq_out", {30'd0, sq_out}, 32'd0);
      chk("rst_ready", {31'd0, div_wr_ready}, 32'd1);
      rst_from_FPGA = 1'b1;

      // Default divisor 101 on channel 0 only
      go_until(5);
      run = 2'b01;
      s = cyc + 1;
      sq_m[0] = 1'b0;
      push_pulses(0, s + 100, 101, 3);
      go_until(s + 310);
      run = 2'b00;
      go_until(s + 312);
      chk("stop_ce_out", {30'd0, ce_out}, 32'd0);
      chk("stop_sq_out", {30'd0, sq_out}, 32'd0);

      // Stopped channel 1: write 4, then run
      do_write(1, 4, 1'b1);
      run[1] = 1'b1;
      s = cyc + 1;
      sq_m[1] = 1'b0;
      push_pulses(1, s + 3, 4, 4);
      go_until(s + 16);
      run[1] = 1'b0;

      // Channel 0 at div 10, write 3 when counter is 5
      do_write(0, 10, 1'b1);
      run[0] = 1'b1;
      s = cyc + 1;
      sq_m[0] = 1'b0;
      push_pulses(0, s + 9, 10, 2);
      push_pulses(0, s + 22, 3, 3);
      go_until(s + 14);
      do_write(0, 3, 1'b1);
      chk("pend_ready_lo_a", {31'd0, div_wr_ready}, 32'd0);
      go_until(s + 16);
      div_wr_ch = 1'b1;
      #1;
      chk("other_ch_ready", {31'd0, div_wr_ready}, 32'd1);
      div_wr_ch = 1'b0;
      go_until(s + 18);
      chk("pend_ready_lo_b", {31'd0, div_wr_ready}, 32'd0);
      go_until(s + 19);
      chk("pend_ready_hi", {31'd0, div_wr_ready}, 32'd1);
      go_until(s + 28);
      run[0] = 1'b0;

      // Divisor 0 then 1 on stopped channel 1: continuous enable
      do_write(1, 0, 1'b1);
      run[1] = 1'b1;
      s = cyc + 1;
      sq_m[1] = 1'b0;
      push_pulses(1, s, 1, 6);
      go_until(s + 5);
      run[1] = 1'b0;
      go_until(s + 6);
      do_write(1, 1, 1'b1);
      run[1] = 1'b1;
      s = cyc + 1;
      sq_m[1] = 1'b0;
      push_pulses(1, s, 1, 6);
      go_until(s + 5);
      run[1] = 1'b0;
      go_until(s + 6);

      // Write on the terminal-count edge
      do_write(0, 6, 1'b1);
      run[0] = 1'b1;
      s = cyc + 1;
      sq_m[0] = 1'b0;
      push_pulses(0, s + 5, 6, 3);
      push_pulses(0, s + 19, 2, 2);
      go_until(s + 10);
      do_write(0, 2, 1'b1);
      chk("term_wr_pending", {31'd0, div_wr_ready}, 32'd0);
      go_until(s + 21);
      run[0] = 1'b0;
      go_until(s + 23);

      // Reset mid-period
      run[0] = 1'b1;
      s = cyc + 1;
      sq_m[0] = 1'b0;
      push_pulses(0, s + 1, 2, 1);
      go_until(s + 1);
      rst_from_FPGA = 1'b0;
      #1;
      chk("async_rst_ce", {30'd0, ce_out}, 32'd0);
      chk("async_rst_sq", {30'd0, sq_out}, 32'd0);
      run = 2'b00;
      go_until(cyc + 3);
      rst_from_FPGA = 1'b1;
      div_wr_ch = 1'b0;
      #1;
      chk("post_rst_ready", {31'd0, div_wr_ready}, 32'd1);
      run = 2'b11;
      s = cyc + 1;
      sq_m[0] = 1'b0;
      sq_m[1] = 1'b0;
      push_pulses(0, s + 100, 101, 1);
      push_pulses(1, s + 100, 101, 1);
      go_until(s + 101);
      run = 2'b00;
      go_until(cyc + 2);

      for (int i = 0; i < NUM_CH; i++) begin
         chk($sformatf("missing_pulses_ch%0d", i), exp_q[i].size(), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
